logic_plotter: RTL and testbench

LOGIC_PLOTTER -- requirements
Module: logic_plotter

---
 rtl/logic_plotter_pkg.sv | 14 +
 rtl/logic_plotter_if.sv | 25 ++
 rtl/logic_plotter_capture.sv | 107 ++++++++++
 rtl/logic_plotter.sv | 120 ++++++++++++
 tb/tb_logic_plotter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_plotter_pkg.sv
// Shared types and display geometry for the logic plotter.
package logic_plotter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } state_t;

    localparam int SAMPLES_PER_ROW_LOG2 = 9;
    localparam int LINES_PER_BAND_LOG2  = 3;

endpackage

// File: rtl/logic_plotter_if.sv
// VGA side of the plotter: timing-generator inputs and registered colour/sync outputs.
interface logic_plotter_if;

    logic [9:0] vga_x;
    logic [9:0] vga_y;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       vga_blank;
    logic       r;
    logic       g;
    logic       b;
    logic       hsync;
    logic       vsync;

    modport master (
        output vga_x, vga_y, vga_hsync, vga_vsync, vga_blank,
        input  r, g, b, hsync, vsync
    );

    modport slave (
        input  vga_x, vga_y, vga_hsync, vga_vsync, vga_blank,
        output r, g, b, hsync, vsync
    );

endinterface

// File: rtl/logic_plotter_capture.sv
// Capture control: FSM, prescaler and write counter. Define PLOTTER_TRIGGER_EN to
// wait for the trigger pattern before capturing; otherwise start captures at once.
module logic_plotter_capture
    import logic_plotter_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int DEPTH_LOG2     = 14,
    parameter int PRESCALE_WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       data_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [CHANNELS-1:0]       trigger_mask,
    input  logic [CHANNELS-1:0]       trigger_value,
    output logic                      wr_en,
    output logic [DEPTH_LOG2-1:0]     wr_addr,
    output logic [CHANNELS-1:0]       wr_data,
    output logic [DEPTH_LOG2:0]       count,
    output state_t                    state,
    output logic                      busy,
    output logic                      done
);

    localparam logic [DEPTH_LOG2:0]       LAST_ADDR = {1'b0, {DEPTH_LOG2{1'b1}}};
    localparam logic [DEPTH_LOG2:0]       COUNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE   = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    state_t                    state_d;
    logic [DEPTH_LOG2:0]       count_d;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic [PRESCALE_WIDTH-1:0] pre_d;
    logic                      tick;
    logic                      trig_hit;

`ifdef PLOTTER_TRIGGER_EN
    localparam state_t START_STATE = ARMED;
    assign trig_hit = ((data_in ^ trigger_value) & trigger_mask) == '0;
`else
    localparam state_t START_STATE = CAPTURE;
    logic unused_trigger;
    assign unused_trigger = ^{trigger_mask, trigger_value};
    assign trig_hit       = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            pre_cnt <= '0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            pre_cnt <= pre_d;
        end
    end

    // start and clear are single-cycle commands sampled on the clock edge; clear wins.
    always_comb begin
        state_d = state;
        count_d = count;
        pre_d   = pre_cnt;
        wr_en   = 1'b0;
        tick    = (pre_cnt == prescale);
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            pre_d   = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = START_STATE;
                        count_d = '0;
                        pre_d   = '0;
                    end
                end
                ARMED: begin
                    pre_d = tick ? '0 : pre_cnt + PRE_ONE;
                    if (tick && trig_hit) begin
                        wr_en   = 1'b1;
                        count_d = COUNT_ONE;
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    pre_d = tick ? '0 : pre_cnt + PRE_ONE;
                    if (tick) begin
                        wr_en   = 1'b1;
                        count_d = count + COUNT_ONE;
                        if (count == LAST_ADDR) state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Count is zero while armed, so the trigger sample lands at address 0.
    assign wr_addr = count[DEPTH_LOG2-1:0];
    assign wr_data = data_in;
    assign busy    = (state == ARMED) || (state == CAPTURE);
    assign done    = (state == DONE);

endmodule

// File: rtl/logic_plotter.sv
// Logic analyser that samples CHANNELS signals into RAM and draws them as VGA traces.
// Trigger-wait behaviour is enabled by defining PLOTTER_TRIGGER_EN.
module logic_plotter
    import logic_plotter_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int DEPTH_LOG2     = 14,
    parameter int PRESCALE_WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       data_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [CHANNELS-1:0]       trigger_mask,
    input  logic [CHANNELS-1:0]       trigger_value,
    logic_plotter_if.slave            vga,
    output logic                      busy,
    output logic                      done,
    output state_t                    fsm_state
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int X_LIMIT = 1 << SAMPLES_PER_ROW_LOG2;
    localparam int Y_LIMIT = 1 << (DEPTH_LOG2 - SAMPLES_PER_ROW_LOG2 + LINES_PER_BAND_LOG2);

    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [CHANNELS-1:0]   wr_data;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [CHANNELS-1:0]   rd_data;
    logic [CHANNELS-1:0]   mem [DEPTH];
    logic                  visible;
    logic                  vis_q, hs_q, vs_q;
    logic [1:0]            chan_q;
    logic [3:0]            sample_ext;
    logic                  sample_bit;
    logic                  r_q, g_q, b_q, hsync_q, vsync_q;

    logic_plotter_capture #(
        .CHANNELS      (CHANNELS),
        .DEPTH_LOG2    (DEPTH_LOG2),
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_capture (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .clear        (clear),
        .data_in      (data_in),
        .prescale     (prescale),
        .trigger_mask (trigger_mask),
        .trigger_value(trigger_value),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .count        (count),
        .state        (fsm_state),
        .busy         (busy),
        .done         (done)
    );

    // Each 8-line band of the screen shows the next 512 samples.
    generate
        if (DEPTH_LOG2 > SAMPLES_PER_ROW_LOG2) begin : g_bands
            assign rd_idx = {vga.vga_y[DEPTH_LOG2-SAMPLES_PER_ROW_LOG2+LINES_PER_BAND_LOG2-1:LINES_PER_BAND_LOG2],
                             vga.vga_x[SAMPLES_PER_ROW_LOG2-1:0]};
        end else begin : g_single_band
            assign rd_idx = vga.vga_x[SAMPLES_PER_ROW_LOG2-1:0];
        end
    endgenerate

    assign visible = !vga.vga_blank
                  && (32'(vga.vga_x) < X_LIMIT)
                  && (32'(vga.vga_y) < Y_LIMIT)
                  && !vga.vga_y[0]
                  && (32'(vga.vga_y[2:1]) < CHANNELS)
                  && ({1'b0, rd_idx} < count);

    // Sample RAM is deliberately not reset; write count gates what is displayed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_idx];
    end

    assign sample_ext = 4'(rd_data);
    assign sample_bit = sample_ext[chan_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vis_q   <= 1'b0;
            chan_q  <= 2'b00;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            r_q     <= 1'b0;
            g_q     <= 1'b0;
            b_q     <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            vis_q   <= visible;
            chan_q  <= vga.vga_y[2:1];
            hs_q    <= vga.vga_hsync;
            vs_q    <= vga.vga_vsync;
            r_q     <= vis_q & ~sample_bit;
            g_q     <= vis_q & sample_bit;
            b_q     <= 1'b0;
            hsync_q <= hs_q;
            vsync_q <= vs_q;
        end
    end

    assign vga.r     = r_q;
    assign vga.g     = g_q;
    assign vga.b     = b_q;
    assign vga.hsync = hsync_q;
    assign vga.vsync = vsync_q;

endmodule

// File: tb/tb_logic_plotter.sv
// Self-checking bench for logic_plotter: behavioural capture/display model plus directed scenarios.
module tb_logic_plotter;

    localparam int CH    = 2;
    localparam int DL    = 10;
    localparam int PW    = 13;
    localparam int DEPTH = 1 << DL;
`ifdef PLOTTER_TRIGGER_EN
    localparam bit TRIG = 1'b1;
`else
    localparam bit TRIG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [CH-1:0] data_in = '0;
    logic [PW-1:0] prescale = '0;
    logic [CH-1:0] trigger_mask = '0;
    logic [CH-1:0] trigger_value = '0;
    logic          busy;
    logic          done;
    logic_plotter_pkg::state_t fsm_state;

    logic_plotter_if vga();

    logic_plotter #(
        .CHANNELS      (CH),
        .DEPTH_LOG2    (DL),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .clear        (clear),
        .data_in      (data_in),
        .prescale     (prescale),
        .trigger_mask (trigger_mask),
        .trigger_value(trigger_value),
        .vga          (vga),
        .busy         (busy),
        .done         (done),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_WAIT, M_RUN, M_FULL} mode_t;
    mode_t         m_mode = M_IDLE;
    int            m_count = 0;
    int            m_since = 0;
    logic [CH-1:0] m_mem [DEPTH];
    logic [4:0]    exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Colour {r,g,b} a pixel must show given the samples captured so far.
    function automatic logic [2:0] model_rgb(input int x, input int y, input bit blank);
        int   idx;
        int   chan;
        if (blank || x >= 512 || y >= 8 * (DEPTH / 512) || (y % 2) != 0) return 3'b000;
        chan = (y % 8) / 2;
        if (chan >= CH) return 3'b000;
        idx = (y / 8) * 512 + x;
        if (idx >= m_count) return 3'b000;
        return m_mem[idx][chan] ? 3'b010 : 3'b100;
    endfunction

    // One clock of capture behaviour: a sample is taken every (prescale+1)-th clock after start.
    function automatic void model_step();
        int p;
        if (clear) begin
            m_mode  = M_IDLE;
            m_count = 0;
            m_since = 0;
        end else if (start && (m_mode == M_IDLE || m_mode == M_FULL)) begin
            m_mode  = TRIG ? M_WAIT : M_RUN;
            m_count = 0;
            m_since = 0;
        end else if (m_mode == M_WAIT || m_mode == M_RUN) begin
            p = int'(prescale);
            if ((m_since % (p + 1)) == p) begin
                if (m_mode == M_WAIT) begin
                    if (((data_in ^ trigger_value) & trigger_mask) == '0) begin
                        m_mem[0] = data_in;
                        m_count  = 1;
                        m_mode   = M_RUN;
                    end
                end else begin
                    m_mem[m_count] = data_in;
                    m_count++;
                    if (m_count == DEPTH) m_mode = M_FULL;
                end
            end
            m_since++;
        end
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(posedge clk) begin
        logic [4:0] pix;
        logic [4:0] cur;
        logic [6:0] exp_v;
        if (reset) begin
            m_mode  = M_IDLE;
            m_count = 0;
            m_since = 0;
            exp_q.delete();
            exp_q.push_back(5'b0);
            exp_v = 7'b0;
        end else begin
            pix = {model_rgb(int'(vga.vga_x), int'(vga.vga_y), vga.vga_blank),
                   vga.vga_hsync, vga.vga_vsync};
            model_step();
            exp_q.push_back(pix);
            cur   = exp_q.pop_front();
            exp_v = {cur, (m_mode == M_WAIT || m_mode == M_RUN), (m_mode == M_FULL)};
        end
        #1;
        check("vga_busy_done",
              32'({vga.r, vga.g, vga.b, vga.hsync, vga.vsync, busy, done}), 32'(exp_v));
    end

    // ---------------- driver tasks ----------------
    task automatic tick_clk();
        @(posedge clk);
        #2;
    endtask

    task automatic park();
        vga.vga_x     = 10'd700;
        vga.vga_y     = 10'd0;
        vga.vga_blank = 1'b1;
        vga.vga_hsync = 1'b0;
        vga.vga_vsync = 1'b0;
    endtask

    task automatic do_clear(input int p);
        clear    = 1'b1;
        prescale = PW'(p);
        tick_clk();
        clear    = 1'b0;
    endtask

    task automatic show_pixel(input int x, input int y, input bit hs, output logic [3:0] o);
        vga.vga_x     = 10'(x);
        vga.vga_y     = 10'(y);
        vga.vga_blank = 1'b0;
        vga.vga_hsync = hs;
        tick_clk();
        park();
        tick_clk();
        o = {vga.r, vga.g, vga.b, vga.hsync};
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] o;
        int         got;
        bit         busy_ok;

        park();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        check("reset_busy_done", 32'({busy, done}), 32'(0));
        check("reset_vga", 32'({vga.r, vga.g, vga.b, vga.hsync, vga.vsync}), 32'(0));

        // start and clear together from IDLE
        start = 1'b1;
        clear = 1'b1;
        tick_clk();
        start = 1'b0;
        clear = 1'b0;
        check("start_clear_busy", 32'(busy), 32'(0));
        check("start_clear_state", 32'(fsm_state), 32'(logic_plotter_pkg::IDLE));

        // full capture at prescale 3
        trigger_mask = '0;
        do_clear(3);
        start   = 1'b1;
        data_in = CH'($urandom_range(0, 3));
        tick_clk();
        start = 1'b0;
        got   = -1;
        for (int i = 1; i <= 5000 && got < 0; i++) begin
            data_in = CH'($urandom_range(0, 3));
            tick_clk();
            if (i == 400) check("model_rate", 32'(m_count), 32'(100));
            if (done) got = i;
        end
        check("done_latency", 32'(got), 32'(4 * DEPTH));
        check("busy_at_done", 32'(busy), 32'(0));
        for (int y = 0; y < 18; y++) begin
            for (int x = 0; x < 512; x++) begin
                vga.vga_x     = 10'(x);
                vga.vga_y     = 10'(y);
                vga.vga_blank = 1'b0;
                vga.vga_hsync = (x == 0);
                vga.vga_vsync = (y == 0);
                tick_clk();
            end
        end
        park();
        show_pixel(5, 0, 1'b0, o);
        check("scan_drawn", 32'(o[3] ^ o[2]), 32'(1));

        // reset mid-capture at count 37
        do_clear(0);
        start   = 1'b1;
        data_in = 2'b11;
        tick_clk();
        start = 1'b0;
        for (int i = 0; i < 100 && m_count < 37; i++) tick_clk();
        check("model_count37", 32'(m_count), 32'(37));
        reset = 1'b1;
        start = 1'b1;
        tick_clk();
        tick_clk();
        check("reset_mid_outputs",
              32'({vga.r, vga.g, vga.b, vga.hsync, vga.vsync, busy, done}), 32'(0));
        reset = 1'b0;
        start = 1'b0;
        tick_clk();
        check("reset_mid_state", 32'(fsm_state), 32'(logic_plotter_pkg::IDLE));
        show_pixel(0, 0, 1'b0, o);
        check("reset_black_0", 32'(o), 32'(0));
        show_pixel(36, 0, 1'b0, o);
        check("reset_black_36", 32'(o), 32'(0));

        // 600 samples at prescale 1, probe index 599 and 600
        do_clear(1);
        data_in = 2'b01;
        start   = 1'b1;
        tick_clk();
        start = 1'b0;
        repeat (1200) tick_clk();
        check("model_count600", 32'(m_count), 32'(600));
        vga.vga_x     = 10'd87;
        vga.vga_y     = 10'd8;
        vga.vga_blank = 1'b0;
        vga.vga_hsync = 1'b1;
        tick_clk();
        vga.vga_x     = 10'd88;
        vga.vga_hsync = 1'b0;
        tick_clk();
        check("idx599_drawn_hsync", 32'({vga.r, vga.g, vga.b, vga.hsync}), 32'(4'b0101));
        park();
        tick_clk();
        check("idx600_black", 32'({vga.r, vga.g, vga.b, vga.hsync}), 32'(4'b0000));

        // channel line layout with ch1=1, ch0=0
        do_clear(0);
        data_in = 2'b10;
        start   = 1'b1;
        tick_clk();
        start = 1'b0;
        repeat (5) tick_clk();
        show_pixel(0, 0, 1'b0, o);
        check("line0_red", 32'(o[3:1]), 32'(3'b100));
        show_pixel(0, 2, 1'b0, o);
        check("line2_green", 32'(o[3:1]), 32'(3'b010));
        show_pixel(0, 1, 1'b0, o);
        check("line1_black", 32'(o[3:1]), 32'(0));
        show_pixel(0, 3, 1'b0, o);
        check("line3_black", 32'(o[3:1]), 32'(0));
        show_pixel(0, 4, 1'b0, o);
        check("line4_black", 32'(o[3:1]), 32'(0));
        show_pixel(0, 6, 1'b0, o);
        check("line6_black", 32'(o[3:1]), 32'(0));

        // trigger wait: mask 01, value 01, data 0 for 100 clocks then 1
        do_clear(0);
        trigger_mask  = 2'b01;
        trigger_value = 2'b01;
        data_in       = 2'b00;
        start         = 1'b1;
        tick_clk();
        start   = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick_clk();
            if (!busy) busy_ok = 1'b0;
        end
        check("busy_while_waiting", 32'(busy_ok), 32'(1));
        data_in = 2'b01;
        repeat (3) tick_clk();
        show_pixel(0, 0, 1'b0, o);
        check("first_sample_ch0", 32'(o[3:1]), TRIG ? 32'(3'b010) : 32'(3'b100));
        show_pixel(0, 2, 1'b0, o);
        check("first_sample_ch1", 32'(o[3:1]), 32'(3'b100));

        // randomized traffic
        do_clear(int'($urandom_range(0, 1)));
        for (int i = 0; i < 4000; i++) begin
            data_in       = CH'($urandom_range(0, 3));
            clear         = ($urandom_range(0, 299) == 0);
            start         = ($urandom_range(0, 39) == 0);
            if (clear) prescale = PW'($urandom_range(0, 1));
            trigger_mask  = CH'($urandom_range(0, 3));
            trigger_value = CH'($urandom_range(0, 3));
            vga.vga_x     = 10'($urandom_range(0, 639));
            vga.vga_y     = 10'($urandom_range(0, 20));
            vga.vga_blank = ($urandom_range(0, 7) == 0);
            vga.vga_hsync = 1'($urandom_range(0, 1));
            vga.vga_vsync = 1'($urandom_range(0, 1));
            tick_clk();
        end
        clear = 1'b0;
        start = 1'b0;
        park();
        repeat (3) tick_clk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
